// File: rtl/window_controller.sv
// Register-window controller: tracks the current window pointer (CWP) and
// the window-invalid mask (WIM), and serves Save/Restore window-shift
// requests.
//
// Build option WINCTL_AUTOSPILL_EN:
//   defined   - a request into an invalid window spills or fills 16 words
//               between the register file and memory, then completes.
//   undefined - a request into an invalid window completes with a trap
//               pulse. CWP and WIM are left unchanged. The memory and
//               register-file strobes stay low.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for a request; a valid shift completes from here
// SPILL_REQ  | first cycle of a spill word write (MemAck ignored)
// SPILL_WAIT | spill word write waiting for MemAck
// FILL_REQ   | first cycle of a fill word read (MemAck ignored)
// FILL_WAIT  | fill word read waiting for MemAck
// FILL_WR    | one-cycle register-file write of the word just read
// DONE       | Ack pulse after a spill or fill, then back to IDLE
module window_controller (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        save_i,
    input  logic        restore_i,
    output logic        ack_o,
    output logic        busy_o,
    output logic [1:0]  cwp_o,
    input  logic        wim_we_i,
    input  logic [3:0]  wim_in_i,
    output logic [3:0]  wim_o,
    output logic        trap_o,
    output logic [1:0]  trap_type_o,
    input  logic [31:0] sp_in_i,
    output logic        mem_req_o,
    output logic        mem_wr_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    output logic [1:0]  win_sel_o,
    output logic [4:0]  ra_o,
    output logic [4:0]  rc_o,
    output logic        rfe_o
);

`ifdef WINCTL_AUTOSPILL_EN
    localparam bit AUTOSPILL = 1'b1;
`else
    localparam bit AUTOSPILL = 1'b0;
`endif

    localparam logic [1:0] TRAP_OVF = 2'b01;
    localparam logic [1:0] TRAP_UNF = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        SPILL_REQ,
        SPILL_WAIT,
        FILL_REQ,
        FILL_WAIT,
        FILL_WR,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cwp_q, cwp_d;
    logic [3:0]  wim_q, wim_d;
    logic [3:0]  k_q, k_d;
    logic [1:0]  tgt_q, tgt_d;
    logic        ack_q, ack_d;
    logic        trap_q, trap_d;
    logic [1:0]  trap_type_q, trap_type_d;

    logic        req_any;
    logic        req_accept;
    logic [1:0]  req_tgt;
    logic [1:0]  spill_win;
    logic [1:0]  fill_next;

    // Save has priority when both are high. No new request is taken while
    // Ack is showing, because the requester still holds its level then.
    assign req_any    = save_i | restore_i;
    assign req_accept = req_any & ~ack_q;
    assign req_tgt    = save_i ? (cwp_q - 2'd1) : (cwp_q + 2'd1);

    // Spill source window is two behind CWP, one behind the save target.
    assign spill_win  = tgt_q - 2'd1;
    assign fill_next  = tgt_q + 2'd1;

    // State and architectural registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            cwp_q       <= 2'd0;
            wim_q       <= 4'b0010;
            k_q         <= 4'd0;
            tgt_q       <= 2'd0;
            ack_q       <= 1'b0;
            trap_q      <= 1'b0;
            trap_type_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            cwp_q       <= cwp_d;
            wim_q       <= wim_d;
            k_q         <= k_d;
            tgt_q       <= tgt_d;
            ack_q       <= ack_d;
            trap_q      <= trap_d;
            trap_type_q <= trap_type_d;
        end
    end

    // Next-state logic: request decode, word counter, window/mask updates.
    always_comb begin
        state_d     = state_q;
        cwp_d       = cwp_q;
        wim_d       = wim_q;
        k_d         = k_q;
        tgt_d       = tgt_q;
        ack_d       = 1'b0;
        trap_d      = 1'b0;
        trap_type_d = trap_type_q;

        case (state_q)
            IDLE: begin
                if (req_accept) begin
                    if (!wim_q[req_tgt]) begin
                        cwp_d = req_tgt;
                        ack_d = 1'b1;
                    end else if (AUTOSPILL) begin
                        tgt_d   = req_tgt;
                        k_d     = 4'd0;
                        state_d = save_i ? SPILL_REQ : FILL_REQ;
                    end else begin
                        ack_d       = 1'b1;
                        trap_d      = 1'b1;
                        trap_type_d = save_i ? TRAP_OVF : TRAP_UNF;
                    end
                end else if (wim_we_i && !req_any) begin
                    wim_d = wim_in_i;
                end
            end

            SPILL_REQ: begin
                state_d = SPILL_WAIT;
            end

            SPILL_WAIT: begin
                if (mem_ack_i) begin
                    if (k_q == 4'd15) begin
                        wim_d   = 4'b0001 << spill_win;
                        cwp_d   = tgt_q;
                        ack_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        k_d     = k_q + 4'd1;
                        state_d = SPILL_REQ;
                    end
                end
            end

            FILL_REQ: begin
                state_d = FILL_WAIT;
            end

            FILL_WAIT: begin
                if (mem_ack_i) begin
                    state_d = FILL_WR;
                end
            end

            FILL_WR: begin
                if (k_q == 4'd15) begin
                    wim_d   = 4'b0001 << fill_next;
                    cwp_d   = tgt_q;
                    ack_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    k_d     = k_q + 4'd1;
                    state_d = FILL_REQ;
                end
            end

            DONE: begin
                k_d     = 4'd0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory and register-file strobes decoded from the current state.
    always_comb begin
        mem_req_o  = 1'b0;
        mem_wr_o   = 1'b0;
        mem_addr_o = sp_in_i + {26'd0, k_q, 2'b00};
        win_sel_o  = cwp_q;
        ra_o       = 5'd0;
        rc_o       = 5'd0;
        rfe_o      = 1'b0;

        case (state_q)
            SPILL_REQ, SPILL_WAIT: begin
                mem_req_o = 1'b1;
                mem_wr_o  = 1'b1;
                win_sel_o = spill_win;
                ra_o      = {1'b1, k_q};
            end
            FILL_REQ, FILL_WAIT: begin
                mem_req_o = 1'b1;
            end
            FILL_WR: begin
                rfe_o     = 1'b1;
                win_sel_o = tgt_q;
                rc_o      = {1'b1, k_q};
            end
            default: begin
            end
        endcase
    end

    assign ack_o       = ack_q;
    assign busy_o      = (state_q != IDLE);
    assign cwp_o       = cwp_q;
    assign wim_o       = wim_q;
    assign trap_o      = trap_q;
    assign trap_type_o = trap_type_q;

endmodule

// File: tb/tb_window_controller.sv
module tb_window_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        save, restore;
    logic        ack, busy;
    logic [1:0]  cwp;
    logic        wim_we;
    logic [3:0]  wim_in;
    logic [3:0]  wim;
    logic        trap;
    logic [1:0]  trap_type;
    logic [31:0] sp;
    logic        mem_req, mem_wr;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [1:0]  win_sel;
    logic [4:0]  ra, rc;
    logic        rfe;

    int total = 0;
    int bad   = 0;

    // Memory model / activity log (written only by the monitor process).
    logic [31:0] log_addr [64];
    logic        log_wr   [64];
    logic [1:0]  log_ws   [64];
    logic [4:0]  log_ra   [64];
    logic [4:0]  log_rc   [64];
    logic [1:0]  log_rws  [64];
    int n_mem = 0;
    int n_rfe = 0;
    int n_trap = 0;
    int n_act = 0;
    int mem_c = 0;

    window_controller dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .save_i      (save),
        .restore_i   (restore),
        .ack_o       (ack),
        .busy_o      (busy),
        .cwp_o       (cwp),
        .wim_we_i    (wim_we),
        .wim_in_i    (wim_in),
        .wim_o       (wim),
        .trap_o      (trap),
        .trap_type_o (trap_type),
        .sp_in_i     (sp),
        .mem_req_o   (mem_req),
        .mem_wr_o    (mem_wr),
        .mem_addr_o  (mem_addr),
        .mem_ack_i   (mem_ack),
        .win_sel_o   (win_sel),
        .ra_o        (ra),
        .rc_o        (rc),
        .rfe_o       (rfe)
    );

    always #5 clk = ~clk;

    // Memory answers a request after it has been seen on two negedges,
    // holds MemAck for one cycle, and logs the word it acknowledged.
    initial begin
        mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mem_ack = 1'b0;
                mem_c   = 0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
                mem_c   = 0;
            end else if (mem_req) begin
                mem_c++;
                if (mem_c == 2) begin
                    mem_ack = 1'b1;
                    if (n_mem < 64) begin
                        log_addr[n_mem] = mem_addr;
                        log_wr[n_mem]   = mem_wr;
                        log_ws[n_mem]   = win_sel;
                        log_ra[n_mem]   = ra;
                    end
                    n_mem++;
                end
            end
            if (rfe) begin
                if (n_rfe < 64) begin
                    log_rc[n_rfe]  = rc;
                    log_rws[n_rfe] = win_sel;
                end
                n_rfe++;
            end
            if (trap) n_trap++;
            if (mem_req || rfe) n_act++;
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0; save = 1'b0; restore = 1'b0; wim_we = 1'b0; wim_in = 4'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic set_wim(input logic [3:0] v);
        wim_we = 1'b1; wim_in = v;
        @(negedge clk);
        wim_we = 1'b0;
    endtask

    task automatic fast_req(input logic s, input logic r);
        save = s; restore = r;
        @(negedge clk);
        save = 1'b0; restore = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ack) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (cwp !== 2'd0) begin bad++; $display("FAIL reset_cwp: got %0d expected 0", cwp); end
        total++; if (wim !== 4'b0010) begin bad++; $display("FAIL reset_wim: got %b expected 0010", wim); end
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b expected 0", ack); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        total++; if (trap !== 1'b0) begin bad++; $display("FAIL reset_trap: got %b expected 0", trap); end
        total++; if (trap_type !== 2'b00) begin bad++; $display("FAIL reset_trap_type: got %b expected 00", trap_type); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        total++; if (rfe !== 1'b0) begin bad++; $display("FAIL reset_rfe: got %b expected 0", rfe); end
    endtask

    // Restore from CWP=0 targets window 1, which reset marks invalid.
    task automatic test_restore_invalid();
`ifdef WINCTL_AUTOSPILL_EN
        bit ok;
        int b;
        b = n_rfe;
        sp = 32'h0;
        restore = 1'b1;
        wait_ack(ok);
        restore = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL inv_fill_ack: got timeout expected ack"); end
        total++; if (cwp !== 2'd1) begin bad++; $display("FAIL inv_fill_cwp: got %0d expected 1", cwp); end
        total++; if (wim !== 4'b0100) begin bad++; $display("FAIL inv_fill_wim: got %b expected 0100", wim); end
        total++; if (n_rfe - b !== 16) begin bad++; $display("FAIL inv_fill_rfe_count: got %0d expected 16", n_rfe - b); end
        total++; if (log_rws[b] !== 2'd1) begin bad++; $display("FAIL inv_fill_winsel: got %0d expected 1", log_rws[b]); end
        @(negedge clk);
`else
        restore = 1'b1;
        @(negedge clk);
        total++; if (trap !== 1'b1) begin bad++; $display("FAIL unf_trap: got %b expected 1", trap); end
        total++; if (trap_type !== 2'b10) begin bad++; $display("FAIL unf_trap_type: got %b expected 10", trap_type); end
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL unf_ack: got %b expected 1", ack); end
        total++; if (cwp !== 2'd0) begin bad++; $display("FAIL unf_cwp: got %0d expected 0", cwp); end
        total++; if (wim !== 4'b0010) begin bad++; $display("FAIL unf_wim: got %b expected 0010", wim); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL unf_busy: got %b expected 0", busy); end
        restore = 1'b0;
        @(negedge clk);
        total++; if (trap !== 1'b0) begin bad++; $display("FAIL unf_trap_pulse: got %b expected 0", trap); end
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL unf_ack_pulse: got %b expected 0", ack); end
`endif
    endtask

    task automatic test_save_fast();
        apply_reset();
        set_wim(4'b0000);
        total++; if (wim !== 4'b0000) begin bad++; $display("FAIL wim_write: got %b expected 0000", wim); end
        save = 1'b1;
        @(negedge clk);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL fast_ack: got %b expected 1", ack); end
        total++; if (cwp !== 2'd3) begin bad++; $display("FAIL fast_cwp: got %0d expected 3", cwp); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL fast_busy: got %b expected 0", busy); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL fast_mem_req: got %b expected 0", mem_req); end
        save = 1'b0;
        @(negedge clk);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL fast_ack_pulse: got %b expected 0", ack); end
        total++; if (cwp !== 2'd3) begin bad++; $display("FAIL fast_cwp_hold: got %0d expected 3", cwp); end
    endtask

    task automatic test_wim_during_request();
        save = 1'b1; wim_we = 1'b1; wim_in = 4'hF;
        @(negedge clk);
        total++; if (cwp !== 2'd2) begin bad++; $display("FAIL wimreq_cwp: got %0d expected 2", cwp); end
        total++; if (wim !== 4'b0000) begin bad++; $display("FAIL wimreq_wim: got %b expected 0000", wim); end
        save = 1'b0; wim_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        fast_req(1'b1, 1'b0);
        total++; if (cwp !== 2'd1) begin bad++; $display("FAIL b2b_setup_cwp: got %0d expected 1", cwp); end
        save = 1'b1; restore = 1'b1;
        @(negedge clk);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL b2b_save_ack: got %b expected 1", ack); end
        total++; if (cwp !== 2'd0) begin bad++; $display("FAIL b2b_save_cwp: got %0d expected 0", cwp); end
        save = 1'b0;
        @(negedge clk);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL b2b_gap_ack: got %b expected 0", ack); end
        total++; if (cwp !== 2'd0) begin bad++; $display("FAIL b2b_gap_cwp: got %0d expected 0", cwp); end
        @(negedge clk);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL b2b_restore_ack: got %b expected 1", ack); end
        total++; if (cwp !== 2'd1) begin bad++; $display("FAIL b2b_restore_cwp: got %0d expected 1", cwp); end
        restore = 1'b0;
        @(negedge clk);
    endtask

`ifndef WINCTL_AUTOSPILL_EN
    task automatic test_trap_overflow();
        set_wim(4'b0001);
        save = 1'b1;
        @(negedge clk);
        total++; if (trap !== 1'b1) begin bad++; $display("FAIL ovf_trap: got %b expected 1", trap); end
        total++; if (trap_type !== 2'b01) begin bad++; $display("FAIL ovf_trap_type: got %b expected 01", trap_type); end
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL ovf_ack: got %b expected 1", ack); end
        total++; if (cwp !== 2'd1) begin bad++; $display("FAIL ovf_cwp: got %0d expected 1", cwp); end
        total++; if (wim !== 4'b0001) begin bad++; $display("FAIL ovf_wim: got %b expected 0001", wim); end
        save = 1'b0;
        @(negedge clk);
    endtask
`else
    task automatic test_spill();
        bit ok;
        int b;
        apply_reset();
        set_wim(4'b1000);
        sp = 32'h0000_1000;
        b = n_mem;
        save = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL spill_busy: got %b expected 1", busy); end
        wim_we = 1'b1; wim_in = 4'hF;
        @(negedge clk);
        wim_we = 1'b0;
        wait_ack(ok);
        save = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL spill_ack: got timeout expected ack"); end
        total++; if (cwp !== 2'd3) begin bad++; $display("FAIL spill_cwp: got %0d expected 3", cwp); end
        total++; if (wim !== 4'b0100) begin bad++; $display("FAIL spill_wim: got %b expected 0100", wim); end
        total++; if (n_mem - b !== 16) begin bad++; $display("FAIL spill_count: got %0d expected 16", n_mem - b); end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (log_addr[b+i] !== 32'h1000 + 32'(i*4) || log_ra[b+i] !== 5'(16+i) ||
                log_ws[b+i] !== 2'd2 || log_wr[b+i] !== 1'b1) begin
                bad++;
                $display("FAIL spill_word%0d: got addr=%h ra=%0d ws=%0d wr=%b expected addr=%h ra=%0d ws=2 wr=1",
                         i, log_addr[b+i], log_ra[b+i], log_ws[b+i], log_wr[b+i], 32'h1000 + 32'(i*4), 16+i);
            end
        end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL spill_idle: got %b expected 0", busy); end
    endtask

    task automatic test_fill();
        bit ok;
        int bm, br;
        apply_reset();
        set_wim(4'b0000);
        fast_req(1'b1, 1'b0);
        set_wim(4'b0001);
        sp = 32'hFFFF_FFF0;
        bm = n_mem; br = n_rfe;
        restore = 1'b1;
        wait_ack(ok);
        restore = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL fill_ack: got timeout expected ack"); end
        total++; if (cwp !== 2'd0) begin bad++; $display("FAIL fill_cwp: got %0d expected 0", cwp); end
        total++; if (wim !== 4'b0010) begin bad++; $display("FAIL fill_wim: got %b expected 0010", wim); end
        total++; if (n_mem - bm !== 16) begin bad++; $display("FAIL fill_read_count: got %0d expected 16", n_mem - bm); end
        total++; if (n_rfe - br !== 16) begin bad++; $display("FAIL fill_rfe_count: got %0d expected 16", n_rfe - br); end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (log_addr[bm+i] !== 32'hFFFF_FFF0 + 32'(i*4) || log_wr[bm+i] !== 1'b0 ||
                log_rc[br+i] !== 5'(16+i) || log_rws[br+i] !== 2'd0) begin
                bad++;
                $display("FAIL fill_word%0d: got addr=%h wr=%b rc=%0d ws=%0d expected addr=%h wr=0 rc=%0d ws=0",
                         i, log_addr[bm+i], log_wr[bm+i], log_rc[br+i], log_rws[br+i], 32'hFFFF_FFF0 + 32'(i*4), 16+i);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_spill();
        bit found;
        apply_reset();
        set_wim(4'b1000);
        sp = 32'h0000_1000;
        save = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mem_req && ra == 5'd23) begin
                found = 1'b1;
                break;
            end
        end
        total++; if (!found) begin bad++; $display("FAIL midrst_reach_k7: got timeout expected k=7"); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (cwp !== 2'd0) begin bad++; $display("FAIL midrst_cwp: got %0d expected 0", cwp); end
        total++; if (wim !== 4'b0010) begin bad++; $display("FAIL midrst_wim: got %b expected 0010", wim); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL midrst_mem_req: got %b expected 0", mem_req); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        save = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL midrst_after: got busy=%b req=%b expected 0 0", busy, mem_req); end
    endtask
`endif

    initial begin
        rst_n = 1'b0; save = 1'b0; restore = 1'b0; wim_we = 1'b0; wim_in = 4'h0; sp = 32'h0;
        @(negedge clk);
        test_reset();
        test_restore_invalid();
        test_save_fast();
        test_wim_during_request();
        test_back_to_back();
`ifdef WINCTL_AUTOSPILL_EN
        test_spill();
        test_fill();
        test_reset_mid_spill();
        total++; if (n_trap !== 0) begin bad++; $display("FAIL no_trap_autospill: got %0d expected 0", n_trap); end
`else
        test_trap_overflow();
        total++; if (n_act !== 0) begin bad++; $display("FAIL no_mem_activity: got %0d expected 0", n_act); end
        total++; if (n_trap !== 2) begin bad++; $display("FAIL trap_pulse_count: got %0d expected 2", n_trap); end
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
